// File: rtl/timer_multi_pkg.sv
// timer_multi shared definitions: register offsets, CTRL bits, reset values.
// Optional compare/interrupt logic is built when TIMER_MULTI_IRQ_EN is defined.
package timer_multi_pkg;

  typedef enum logic [1:0] {
    REG_VALUE = 2'd0,
    REG_DIV   = 2'd1,
    REG_CMP   = 2'd2,
    REG_CTRL  = 2'd3
  } reg_e;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_ARL = 1;
  localparam int CTRL_IE  = 2;
  localparam int CTRL_MF  = 8;

  localparam logic        RST_EN    = 1'b1;
  localparam logic [31:0] RST_VALUE = 32'h0000_0000;
  localparam logic [31:0] RST_DIV   = 32'h0000_0000;
  localparam logic [31:0] RST_CMP   = 32'hFFFF_FFFF;

  localparam logic [31:0] RD_UNMAPPED = 32'hFFFF_FFFF;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, VALUE/DIV/CMP/CTRL registers, irq flop.
// Compare, auto-reload and interrupt exist only with TIMER_MULTI_IRQ_EN.
module timer_channel
  import timer_multi_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  reg_e        sel_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  logic [CNT_W-1:0] value_q, value_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] wval;
  logic             wr_value, wr_div, wr_ctrl;
  logic             tick;
  logic             reload;
  logic [31:0]      ctrl_rd;
  logic [31:0]      cmp_rd;
  logic             unused_wdata;

  assign wval     = wdata_i[CNT_W-1:0];
  assign wr_value = we_i && (sel_i == REG_VALUE);
  assign wr_div   = we_i && (sel_i == REG_DIV);
  assign wr_ctrl  = we_i && (sel_i == REG_CTRL);
  assign unused_wdata = ^wdata_i;

  // Tick when the prescaler has reached DIV (or DIV was lowered below it)
  assign tick = en_q && (pcnt_q >= div_q);

`ifdef TIMER_MULTI_IRQ_EN
  logic [CNT_W-1:0] cmp_q, cmp_d;
  logic             arl_q, arl_d;
  logic             ie_q, ie_d;
  logic             mf_q, mf_d;
  logic             irq_q;
  logic             hit;

  assign hit    = tick && (value_q == cmp_q);
  assign reload = hit && arl_q;

  // Compare/control next state; a match outranks a same-cycle MF clear
  always_comb begin
    cmp_d = cmp_q;
    arl_d = arl_q;
    ie_d  = ie_q;
    mf_d  = mf_q;
    if (we_i && (sel_i == REG_CMP)) cmp_d = wval;
    if (wr_ctrl) begin
      arl_d = wdata_i[CTRL_ARL];
      ie_d  = wdata_i[CTRL_IE];
      if (wdata_i[CTRL_MF]) mf_d = 1'b0;
    end
    if (hit) mf_d = 1'b1;
  end

  // Compare/control state and registered interrupt level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmp_q <= RST_CMP[CNT_W-1:0];
      arl_q <= 1'b0;
      ie_q  <= 1'b0;
      mf_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
      arl_q <= arl_d;
      ie_q  <= ie_d;
      mf_q  <= mf_d;
      irq_q <= mf_q & ie_q;
    end
  end

  assign irq_o  = irq_q;
  assign cmp_rd = 32'(cmp_q);

  // CTRL readback with all implemented bits
  always_comb begin
    ctrl_rd           = '0;
    ctrl_rd[CTRL_EN]  = en_q;
    ctrl_rd[CTRL_ARL] = arl_q;
    ctrl_rd[CTRL_IE]  = ie_q;
    ctrl_rd[CTRL_MF]  = mf_q;
  end
`else
  assign reload = 1'b0;
  assign irq_o  = 1'b0;
  assign cmp_rd = RD_UNMAPPED;

  // CTRL readback carries only EN in this build
  always_comb begin
    ctrl_rd          = '0;
    ctrl_rd[CTRL_EN] = en_q;
  end
`endif

  // Counter, prescaler and divider next state; a VALUE write beats a tick
  always_comb begin
    value_d = value_q;
    pcnt_d  = pcnt_q;
    div_d   = div_q;
    en_d    = en_q;
    if (en_q) pcnt_d = tick ? '0 : pcnt_q + CNT_W'(1);
    if (tick) value_d = reload ? '0 : value_q + CNT_W'(1);
    if (wr_value) value_d = wval;
    if (wr_div) div_d = wval;
    if (wr_ctrl) en_d = wdata_i[CTRL_EN];
  end

  // Counter, prescaler, divider and enable state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= RST_VALUE[CNT_W-1:0];
      div_q   <= RST_DIV[CNT_W-1:0];
      pcnt_q  <= '0;
      en_q    <= RST_EN;
    end else begin
      value_q <= value_d;
      div_q   <= div_d;
      pcnt_q  <= pcnt_d;
      en_q    <= en_d;
    end
  end

  // Register readback for the selected offset
  always_comb begin
    rdata_o = RD_UNMAPPED;
    unique case (sel_i)
      REG_VALUE: rdata_o = 32'(value_q);
      REG_DIV:   rdata_o = 32'(div_q);
      REG_CMP:   rdata_o = cmp_rd;
      REG_CTRL:  rdata_o = ctrl_rd;
      default:   rdata_o = RD_UNMAPPED;
    endcase
  end

endmodule

// File: rtl/timer_multi.sv
// Multi-channel MMIO timer: address decode, channel array, read mux.
// Define TIMER_MULTI_IRQ_EN to build compare/auto-reload/interrupt logic.
module timer_multi
  import timer_multi_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int CNT_W = 32
) (
  input  logic            timer_clk,
  input  logic            timer_rst,
  input  logic [31:0]     timer_addr,
  input  logic            timer_we,
  input  logic [31:0]     timer_raw_wdata,
  output logic [31:0]     timer_wdata,
  output logic [N_CH-1:0] timer_irq
);

  logic [2:0]  ch_sel;
  reg_e        reg_sel;
  logic [31:0] ch_rdata [N_CH];
  logic        unused_addr;

  assign ch_sel      = timer_addr[6:4];
  assign reg_sel     = reg_e'(timer_addr[3:2]);
  assign unused_addr = ^{timer_addr[31:7], timer_addr[1:0]};

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i  (timer_clk),
      .rst_i  (timer_rst),
      .we_i   (timer_we && (ch_sel == 3'(g))),
      .sel_i  (reg_sel),
      .wdata_i(timer_raw_wdata),
      .rdata_o(ch_rdata[g]),
      .irq_o  (timer_irq[g])
    );
  end

  // Read mux; channels beyond N_CH read as unmapped
  always_comb begin
    timer_wdata = RD_UNMAPPED;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel == 3'(i)) timer_wdata = ch_rdata[i];
    end
  end

endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi: directed cases plus random traffic
// against a behavioural model; follows TIMER_MULTI_IRQ_EN if defined.
module tb_timer_multi;

  localparam int N_CH = 2;
`ifdef TIMER_MULTI_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  localparam logic [31:0] CMP_RD5 = IRQ ? 32'd5 : 32'hFFFF_FFFF;

  logic            clk = 1'b0;
  logic            rst;
  logic            we;
  logic [31:0]     addr;
  logic [31:0]     wd;
  logic [31:0]     rd;
  logic [N_CH-1:0] irq;

  always #5 clk = ~clk;

  timer_multi #(
    .N_CH (N_CH),
    .CNT_W(32)
  ) dut (
    .timer_clk      (clk),
    .timer_rst      (rst),
    .timer_addr     (addr),
    .timer_we       (we),
    .timer_raw_wdata(wd),
    .timer_wdata    (rd),
    .timer_irq      (irq)
  );

  logic [31:0]     m_val [N_CH];
  logic [31:0]     m_div [N_CH];
  logic [31:0]     m_cmp [N_CH];
  logic [31:0]     m_pc  [N_CH];
  bit              m_en  [N_CH];
  bit              m_arl [N_CH];
  bit              m_ie  [N_CH];
  bit              m_mf  [N_CH];
  logic [N_CH-1:0] m_irq;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(logic [31:0] a);
    int c;
    c = int'(a[6:4]);
    if (c >= N_CH) return 32'hFFFF_FFFF;
    case (a[3:2])
      2'd0: return m_val[c];
      2'd1: return m_div[c];
      2'd2: return IRQ ? m_cmp[c] : 32'hFFFF_FFFF;
      default:
        if (IRQ)
          return {23'd0, m_mf[c], 5'd0, m_ie[c], m_arl[c], m_en[c]};
        else
          return {31'd0, m_en[c]};
    endcase
  endfunction

  task automatic m_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_val[c] = 0;
      m_div[c] = 0;
      m_cmp[c] = 32'hFFFF_FFFF;
      m_pc[c]  = 0;
      m_en[c]  = 1'b1;
      m_arl[c] = 1'b0;
      m_ie[c]  = 1'b0;
      m_mf[c]  = 1'b0;
    end
    m_irq = '0;
  endtask

  task automatic m_step(bit r, bit w, logic [31:0] a, logic [31:0] d);
    if (r) begin
      m_reset();
      return;
    end
    for (int c = 0; c < N_CH; c++) begin
      bit wr;
      bit tk;
      bit hit;
      int rg;
      wr = w && (int'(a[6:4]) == c);
      rg = int'(a[3:2]);
      m_irq[c] = IRQ && m_mf[c] && m_ie[c];
      tk = m_en[c] && (m_pc[c] >= m_div[c]);
      if (m_en[c]) m_pc[c] = tk ? 32'd0 : m_pc[c] + 32'd1;
      hit = IRQ && tk && (m_val[c] == m_cmp[c]);
      if (tk) m_val[c] = (hit && m_arl[c]) ? 32'd0 : m_val[c] + 32'd1;
      if (hit) m_mf[c] = 1'b1;
      else if (wr && rg == 3 && d[8]) m_mf[c] = 1'b0;
      if (wr) begin
        case (rg)
          0: m_val[c] = d;
          1: m_div[c] = d;
          2: if (IRQ) m_cmp[c] = d;
          default: begin
            m_en[c] = d[0];
            if (IRQ) begin
              m_arl[c] = d[1];
              m_ie[c]  = d[2];
            end
          end
        endcase
      end
    end
  endtask

  task automatic cyc(bit r, bit w, logic [31:0] a, logic [31:0] d);
    rst  = r;
    we   = w;
    addr = a;
    wd   = d;
    #1;
    if (!r) begin
      chk("rd", rd, m_read(a));
      chk("irq", 32'(irq), 32'(m_irq));
    end
    @(posedge clk);
    m_step(r, w, a, d);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic peek(string tag, logic [31:0] a, logic [31:0] exp);
    rst  = 1'b0;
    we   = 1'b0;
    addr = a;
    #1;
    chk(tag, rd, exp);
  endtask

  initial begin
    rst  = 1'b1;
    we   = 1'b0;
    addr = 32'h0;
    wd   = 32'h0;
    m_reset();

    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    peek("rst_value", 32'h00, 32'h0);
    peek("rst_div", 32'h04, 32'h0);
    peek("rst_ctrl", 32'h0C, 32'h1);
    peek("rst_cmp", 32'h08, 32'hFFFF_FFFF);
    chk("rst_irq", 32'(irq), 32'h0);

    idle(5);
    peek("cnt5", 32'h00, 32'd5);
    peek("unmapped", 32'h7C, 32'hFFFF_FFFF);

    cyc(1'b0, 1'b1, 32'h14, 32'd3);
    cyc(1'b0, 1'b1, 32'h10, 32'd0);
    idle(12);
    peek("ch1_div3", 32'h10, 32'd3);
    peek("ch0_free", 32'h00, 32'd19);

    cyc(1'b0, 1'b1, 32'h08, 32'd5);
    cyc(1'b0, 1'b1, 32'h00, 32'hFFFF_FFFF);
    peek("wrap_pre", 32'h00, 32'hFFFF_FFFF);
    idle(1);
    peek("wrap", 32'h00, 32'h0);
    peek("wrap_nomf", 32'h0C, 32'h1);

    cyc(1'b0, 1'b1, 32'h00, 32'h10);
    peek("wr_wins", 32'h00, 32'h10);

    cyc(1'b0, 1'b1, 32'h0C, 32'h0);
    peek("en_off", 32'h00, 32'h11);
    idle(10);
    peek("en_hold", 32'h00, 32'h11);
    peek("cmp_rd", 32'h08, CMP_RD5);
    cyc(1'b0, 1'b1, 32'h0C, 32'h1);

`ifdef TIMER_MULTI_IRQ_EN
    cyc(1'b0, 1'b1, 32'h08, 32'd4);
    cyc(1'b0, 1'b1, 32'h0C, 32'h7);
    cyc(1'b0, 1'b1, 32'h00, 32'h0);
    peek("arl_v0", 32'h00, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      idle(1);
      peek("arl_seq", 32'h00, 32'(i % 5));
    end
    peek("mf_set", 32'h0C, 32'h107);
    chk("irq_lag", 32'(irq[0]), 32'h0);
    idle(1);
    chk("irq_rise", 32'(irq[0]), 32'h1);
    cyc(1'b0, 1'b1, 32'h0C, 32'h100);
    peek("w1c", 32'h0C, 32'h0);
    idle(1);
    chk("irq_fall", 32'(irq[0]), 32'h0);
    cyc(1'b0, 1'b1, 32'h00, 32'd4);
    cyc(1'b0, 1'b1, 32'h0C, 32'h7);
    cyc(1'b0, 1'b1, 32'h0C, 32'h105);
    peek("set_wins", 32'h0C, 32'h105);
    peek("arl_zero", 32'h00, 32'h0);
`endif

    cyc(1'b0, 1'b1, 32'h04, 32'd7);
    idle(3);
    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    peek("rst2_value", 32'h00, 32'h0);
    peek("rst2_div", 32'h04, 32'h0);
    peek("rst2_ctrl", 32'h0C, 32'h1);
    peek("rst2_cmp", 32'h08, 32'hFFFF_FFFF);
    chk("rst2_irq", 32'(irq), 32'h0);
    idle(1);
    peek("rst2_count", 32'h00, 32'h1);

    for (int k = 0; k < 3000; k++) begin
      bit          r;
      bit          w;
      int          ch;
      int          rg;
      logic [31:0] a;
      logic [31:0] d;
      r  = ($urandom_range(0, 299) == 0);
      w  = ($urandom_range(0, 2) == 0);
      ch = int'($urandom_range(0, N_CH));
      if (ch == N_CH) ch = int'($urandom_range(N_CH, 7));
      rg = int'($urandom_range(0, 3));
      a  = {25'd0, 3'(ch), 2'(rg), 2'b00};
      case (rg)
        0: d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 12))
                                           : 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        1: d = 32'($urandom_range(0, 3));
        2: d = 32'($urandom_range(0, 12));
        default: begin
          d    = $urandom & 32'h0000_0107;
          d[0] = ($urandom_range(0, 7) != 0);
        end
      endcase
      cyc(r, w, a, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
